// File: rtl/pipe_issue_arbiter.sv
// rtl/pipe_issue_arbiter.sv - round-robin issue arbiter with tagged result routing for the 8-bit pipelined processor
// Optional transfer counter output perf_issued is enabled by PIPE_ARB_PERF_EN.
module pipe_issue_arbiter #(
  parameter int N        = 4,
  parameter int PIPE_LAT = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N*8-1:0] req_instr,
  output logic [N-1:0]   req_ready,
  input  logic           hold,
  output logic [7:0]     instr_out,
  input  logic [7:0]     proc_result,
  output logic [N-1:0]   rsp_valid,
  output logic [7:0]     rsp_data
`ifdef PIPE_ARB_PERF_EN
  ,
  output logic [15:0]    perf_issued
`endif
);

  localparam int ID_W  = (N > 1) ? $clog2(N) : 1;
  localparam int TAG_D = PIPE_LAT + 1;

  logic [ID_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [7:0]                 instr_q, instr_d;
  logic [TAG_D-1:0]           tag_vld_q, tag_vld_d;
  logic [TAG_D-1:0][ID_W-1:0] tag_id_q, tag_id_d;
  logic [N-1:0]               rsp_valid_q, rsp_valid_d;
  logic [7:0]                 rsp_data_q, rsp_data_d;

  logic                       issue_en;
  logic                       grant_any;
  logic [ID_W-1:0]            grant_id;
  logic [ID_W-1:0]            idx;
  logic [N-1:0]               grant_vec;
  logic [7:0]                 grant_instr;

  // Rotating-priority search starting at rr_ptr; hold and reset suppress any grant.
  always_comb begin
    issue_en  = !hold && !rst;
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = ID_W'((int'(rr_ptr_q) + k) % N);
      if (issue_en && !grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
  end

  always_comb begin
    grant_vec   = '0;
    grant_instr = 8'h00;
    for (int k = 0; k < N; k++) begin
      if (grant_any && (grant_id == ID_W'(k))) begin
        grant_vec[k] = 1'b1;
        grant_instr  = req_instr[k*8 +: 8];
      end
    end
  end

  always_comb begin
    instr_d   = grant_any ? grant_instr : 8'h00;
    rr_ptr_d  = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = (grant_id == ID_W'(N-1)) ? '0 : grant_id + ID_W'(1);
    end
    tag_vld_d = {tag_vld_q[TAG_D-2:0], grant_any};
    tag_id_d  = {tag_id_q[TAG_D-2:0], grant_id};
  end

  // The last tag stage lines up with the processor result of the same instruction.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_vld_q[TAG_D-1]) begin
      rsp_data_d = proc_result;
      for (int k = 0; k < N; k++) begin
        rsp_valid_d[k] = (tag_id_q[TAG_D-1] == ID_W'(k));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      instr_q     <= 8'h00;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= 8'h00;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      instr_q     <= instr_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready = grant_vec;
  assign instr_out = instr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

`ifdef PIPE_ARB_PERF_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q + 16'(grant_any);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= 16'h0000;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_issued = perf_q;
`endif

endmodule

// File: tb/tb_pipe_issue_arbiter.sv
// tb/tb_pipe_issue_arbiter.sv - directed and randomized bench for pipe_issue_arbiter with a queue-based model
module tb_pipe_issue_arbiter;
  localparam int N        = 4;
  localparam int PIPE_LAT = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_instr;
  logic [N-1:0]   req_ready;
  logic           hold;
  logic [7:0]     instr_out;
  logic [7:0]     proc_result;
  logic [N-1:0]   rsp_valid;
  logic [7:0]     rsp_data;
`ifdef PIPE_ARB_PERF_EN
  logic [15:0]    perf_issued;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  pipe_issue_arbiter #(.N(N), .PIPE_LAT(PIPE_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_instr   (req_instr),
    .req_ready   (req_ready),
    .hold        (hold),
    .instr_out   (instr_out),
    .proc_result (proc_result),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data)
`ifdef PIPE_ARB_PERF_EN
    ,
    .perf_issued (perf_issued)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu(input logic [7:0] ins);
    logic [7:0] x;
    x = {4'h0, ins[3:0]};
    case (ins[7:4])
      4'h1:    return x + 8'd1;
      4'h2:    return x - 8'd1;
      4'h3:    return x << 1;
      4'h4:    return x >> 1;
      default: return x;
    endcase
  endfunction

  // Stand-in for pipelined_processor: result appears PIPE_LAT edges after the instruction.
  logic [7:0] pstage [PIPE_LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) pstage[i] <= 8'h00;
    end else begin
      pstage[0] <= alu(instr_out);
      for (int i = 1; i < PIPE_LAT; i++) pstage[i] <= pstage[i-1];
    end
  end
  assign proc_result = pstage[PIPE_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    int         due;
    int         id;
    logic [7:0] val;
  } rsp_t;

  rsp_t       exp_q[$];
  int         cyc     = 0;
  int         m_ptr   = 0;
  logic [7:0] m_instr = 8'h00;
  logic [N-1:0] m_gvec = '0;

  // Reference model and per-cycle comparison, sampled mid-cycle.
  always @(negedge clk) begin
    int   g;
    rsp_t r;
    cyc++;
    if (rst) begin
      chk("rst_instr_out", instr_out, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_req_ready", req_ready, 0);
      exp_q.delete();
      m_ptr   = 0;
      m_instr = 8'h00;
      m_gvec  = '0;
    end else begin
      chk("instr_out", instr_out, m_instr);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        chk("rsp_valid", rsp_valid, 1 << exp_q[0].id);
        chk("rsp_data", rsp_data, exp_q[0].val);
        void'(exp_q.pop_front());
      end else begin
        chk("rsp_valid_idle", rsp_valid, 0);
      end
      g = -1;
      if (!hold) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
      end
      m_gvec = '0;
      if (g >= 0) begin
        m_gvec[g] = 1'b1;
        m_instr   = req_instr[g*8 +: 8];
        m_ptr     = (g + 1) % N;
        r.due     = cyc + PIPE_LAT + 2;
        r.id      = g;
        r.val     = alu(req_instr[g*8 +: 8]);
        exp_q.push_back(r);
      end else begin
        m_instr = 8'h00;
      end
      chk("req_ready", req_ready, m_gvec);
    end
  end

  task automatic set_req(input int i, input logic [7:0] v);
    req_valid[i]       = 1'b1;
    req_instr[i*8 +: 8] = v;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    hold      = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [7:0] t2_instr [4] = '{8'h24, 8'h33, 8'h48, 8'h12};
  logic [7:0] t2_exp   [4] = '{8'd3, 8'd6, 8'd4, 8'd3};

  initial begin
    rst = 1'b1; req_valid = '0; req_instr = '0; hold = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single request: INC 2 from requester 0
    set_req(0, 8'h12);
    @(negedge clk); chk("t1_ready", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid = '0;
    chk("t1_instr_out", instr_out, 8'h12);
    repeat (3) @(posedge clk); #1;
    chk("t1_rsp_early", rsp_valid, 0);
    @(posedge clk); #1;
    chk("t1_rsp_valid", rsp_valid, 4'b0001);
    chk("t1_rsp_data", rsp_data, 8'd3);

    // All four requesters at once
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, t2_instr[k]);
    for (int k = 0; k < N; k++) begin
      @(negedge clk); chk("t2_grant", req_ready, 1 << k);
      @(posedge clk); #1 req_valid[k] = 1'b0;
    end
    for (int k = 0; k < N; k++) begin
      @(posedge clk); #1;
      chk("t2_rsp_valid", rsp_valid, 1 << k);
      chk("t2_rsp_data", rsp_data, t2_exp[k]);
    end

    // Fairness between requesters 1 and 3
    set_req(1, 8'h11);
    set_req(3, 8'h31);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); chk("t3_alternate", req_ready, (j % 2 == 0) ? 4'b0010 : 4'b1000);
      @(posedge clk); #1;
    end
    req_valid = '0;
    repeat (6) @(posedge clk); #1;

    // Hold for two cycles with requester 2 waiting, requester 0 in flight
    set_req(0, 8'h15);
    @(negedge clk); chk("t4_pre_grant", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid = '0; set_req(2, 8'h47); hold = 1'b1;
    @(negedge clk); chk("t4_hold_ready", req_ready, 0);
    @(posedge clk); #1 chk("t4_hold_instr", instr_out, 8'h00);
    @(negedge clk); chk("t4_hold_ready", req_ready, 0);
    @(posedge clk); #1 chk("t4_hold_instr", instr_out, 8'h00); hold = 1'b0;
    @(negedge clk); chk("t4_release_grant", req_ready, 4'b0100);
    @(posedge clk); #1 req_valid = '0;
    chk("t4_release_instr", instr_out, 8'h47);
    @(posedge clk); #1;
    chk("t4_inflight_valid", rsp_valid, 4'b0001);
    chk("t4_inflight_data", rsp_data, 8'd6);
    repeat (5) @(posedge clk); #1;

    // Reset one cycle after three back-to-back issues
    set_req(0, 8'h13); set_req(1, 8'h23); set_req(2, 8'h33);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("t5_grant", req_ready, 1 << k);
      @(posedge clk); #1 req_valid[k] = 1'b0;
    end
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("t5_rst_instr", instr_out, 0);
    chk("t5_rst_valid", rsp_valid, 0);
    chk("t5_rst_data", rsp_data, 0);
    chk("t5_rst_ready", req_ready, 0);
    repeat (2) @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1 chk("t5_no_rsp", rsp_valid, 0);
    end

    // Ten issues interleaved with five hold cycles
`ifdef PIPE_ARB_PERF_EN
    chk("t6_perf_start", perf_issued, 0);
`endif
    for (int i = 0; i < 15; i++) begin
      hold = (i % 3 == 2);
      if (!hold && req_valid == '0) set_req(i % N, 8'($urandom));
      @(posedge clk); #1 req_valid = req_valid & ~m_gvec;
    end
    hold = 1'b0;
`ifdef PIPE_ARB_PERF_EN
    chk("t6_perf_count", perf_issued, 10);
`endif
    repeat (PIPE_LAT + 2) @(posedge clk); #1;
    do_reset();
`ifdef PIPE_ARB_PERF_EN
    chk("t6_perf_reset", perf_issued, 0);
`endif

    // Randomized traffic with hold and one mid-run reset
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) set_req(i, 8'($urandom));
      end
      hold = ($urandom_range(0, 4) == 0);
      @(posedge clk); #1 req_valid = req_valid & ~m_gvec;
      if (c == 300) do_reset();
    end
    req_valid = '0;
    hold      = 1'b0;
    repeat (PIPE_LAT + 4) @(posedge clk); #1;
    chk("drain_outstanding", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_issue_arbiter.md
# pipe_issue_arbiter

- Shares the 8-bit pipelined processor between N requesters.
- Arbitrates requests round-robin, drives the processor's `instr_in` with one instruction per cycle, and tags each instruction in flight with its requester ID.
- Each result on the processor's `result_out` is routed back to the requester that issued it.
- Sits directly in front of `pipelined_processor`; it is the only driver of the processor's instruction input.

## Interface
- `N`, 4: number of requesters, 2..8.
- `PIPE_LAT`, 3: processor latency in edges. An instruction driven on `instr_in` after edge E has its result on `result_out` after edge E+PIPE_LAT.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `req_valid` input N: per-requester instruction-valid flag.
- `req_instr` input N*8: per-requester instruction; requester i uses bits [8i+7:8i]. Upper nibble is the opcode (0000 NOP, 0001 INC, 0010 DEC, 0011 SHL, 0100 SHR); lower nibble is the operand.
- `req_ready` input-side handshake output N: one-hot grant; combinational.
- `hold` input 1: stall issue; a NOP is issued instead.
- `instr_out` output 8: registered; connects to the processor's `instr_in`.
- `proc_result` input 8: connects to the processor's `result_out`.
- `rsp_valid` output N: one-hot, registered; one-cycle pulse for the owning requester.
- `rsp_data` output 8: registered result; meaningful only while `rsp_valid` is nonzero.

## Operation
- **Grant:** when `hold`=0 and any `req_valid` bit is set, `req_ready` is asserted for exactly one requester. It is the first requester with valid set, searching from index `rr_ptr` upward and wrapping mod N. Otherwise `req_ready`=0.
- **Handshake:** a transfer occurs when `req_valid[i] & req_ready[i]` is true at a rising edge.
  - Requesters hold `req_valid` and `req_instr` stable until the transfer.
  - `req_ready` never depends on `rsp_valid`.
- **On a transfer of requester g:**
  - `instr_out` <= `req_instr[g]`
  - `rr_ptr` <= (g+1) mod N
  - tag stage 0 <= {1, g}
- **With no transfer (idle or `hold`):**
  - `instr_out` <= 8'h00
  - tag stage 0 <= {0, x}
  - `rr_ptr` is unchanged
- **Tag pipeline:** depth PIPE_LAT+1 stages of {valid, id[$clog2(N)-1:0]}; shifts every cycle with no stall.
- **Response:**
  - When the final tag stage is valid at an edge: `rsp_valid` <= one-hot(id) and `rsp_data` <= `proc_result`.
  - Otherwise `rsp_valid` <= 0 and `rsp_data` holds its previous value.
- **Instruction handling:** the opcode is not decoded. Requester NOPs and unknown opcodes are issued and answered like any other instruction.
- **Round-robin:** a requester that keeps `req_valid` asserted is granted at least once every N issue cycles.

## Timing
- **Reset values:**
  - Outputs: `instr_out`=8'h00, `rsp_valid`=0, `rsp_data`=8'h00, `req_ready`=0 while `rst`=1.
  - Internal state: `rr_ptr`=0, all tag stages invalid.
- **Issue latency:** a request accepted at edge E appears on `instr_out` immediately after E.
- **Response latency:** the request's `rsp_valid` pulse is high from edge E+PIPE_LAT+1 until the next edge.
- **Throughput:** one issue per cycle; back-to-back responses, in issue order.
- **Simultaneous events:** an issue and a response in the same cycle are independent.
- **`hold`:** `hold` rising with `req_valid` set gives no grant and a NOP is issued. Instructions already in flight still complete and respond.
- **Reset mid-operation:** in-flight tags are discarded and no `rsp_valid` is produced for them. The processor is reset by the same `rst`.
- **Wrap-around:** with g=N-1, `rr_ptr` returns to 0.

## Configuration
- Macro: `PIPE_ARB_PERF_EN`.
- **Defined:** adds output `perf_issued` [15:0].
  - Counts accepted transfers and wraps at 16'hFFFF→0.
  - Reset value 0; increments at the edge of each transfer.
- **Undefined:** the port and counter are absent; all other behaviour is identical.

## Test plan
- **Single request:** N=4, PIPE_LAT=3. Requester 0 issues 8'b0001_0010 (INC 2).
  - `instr_out`=8'h12 after the accept edge.
  - `rsp_valid`=4'b0001 and `rsp_data`=3 exactly 4 edges later.
- **All requesters at once:** all 4 assert in the same cycle with DEC 4, SHL 3, SHR 8, INC 2 on requesters 0..3.
  - Grants occur in order 0,1,2,3 on consecutive edges.
  - Responses are 3, 6, 4, 3 with `rsp_valid` 0001, 0010, 0100, 1000 on consecutive cycles.
- **Fairness:** requesters 1 and 3 are continuously valid.
  - Grants alternate 1,3,1,3.
  - `rr_ptr` wraps from 3 to 0 and back to 1.
- **Hold:** assert `hold` for 2 cycles while requester 2 is valid.
  - `req_ready`=0 and `instr_out`=8'h00 for those cycles.
  - Earlier in-flight responses still arrive.
  - Requester 2 is granted on the first edge after `hold` falls.
- **Reset mid-flight:** assert `rst` one cycle after 3 back-to-back issues.
  - All outputs are 0 immediately.
  - No `rsp_valid` ever appears for those 3 instructions.
- **Performance counter:** with `PIPE_ARB_PERF_EN` defined, issue 10 instructions interleaved with 5 hold cycles.
  - `perf_issued`=10.
  - Reset returns it to 0.
